// File: rtl/alu_seq_ctrl_if.sv
// Request/response and shared-ALU bundle for alu_seq_ctrl.
// Handshake: start is a request pulse honoured only while the controller is
// idle (busy=0, done=0). Operands op/opa/opb are captured on the accepting
// clock edge. done is a one-cycle pulse, and result is valid from that cycle
// until the next accepted start. alu_out is the combinational response of the
// external ALU to alu_a/alu_b/alu_sel in the same cycle.
interface alu_seq_ctrl_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_sel;
  logic [31:0] alu_out;

  // Controller side
  modport slave (
    input  start, op, opa, opb, alu_out,
    output busy, done, result, alu_a, alu_b, alu_sel
  );

  // Requester / ALU side
  modport master (
    output start, op, opa, opb, alu_out,
    input  busy, done, result, alu_a, alu_b, alu_sel
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Sequencing controller for a shared 32-bit ALU: multi-cycle shifts
// (one bit per cycle) and a 32-iteration shift-add multiplier.
// All arithmetic goes through the external ALU. Only the iteration counter and
// the multiplier right-shift are computed locally.
module alu_seq_ctrl (
  input  logic              clk,
  input  logic              rst,
  alu_seq_ctrl_if.slave     bus,
  output logic [2:0]        o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SHIFT     = 3'd1,
    S_MUL_ADD   = 3'd2,
    S_MUL_SHIFT = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  localparam logic [1:0] OP_SLA = 2'b00;
  localparam logic [1:0] OP_SRA = 2'b01;
  localparam logic [1:0] OP_SRL = 2'b10;
  localparam logic [1:0] OP_MUL = 2'b11;

  localparam logic [3:0] SEL_ADD = 4'd0;
  localparam logic [3:0] SEL_SLA = 4'd6;
  localparam logic [3:0] SEL_SRA = 4'd7;
  localparam logic [3:0] SEL_SRL = 4'd8;

  state_t      r_state;
  logic [1:0]  r_op;
  logic [31:0] r_acc;      // shift accumulator, or running product
  logic [31:0] r_mcand;
  logic [31:0] r_mplier;
  logic [5:0]  r_cnt;      // remaining shift steps or multiply iterations
  logic [31:0] r_result;
  logic        r_busy;
  logic        r_done;

  logic [31:0] w_alu_a;
  logic [31:0] w_alu_b;
  logic [3:0]  w_alu_sel;

  // Control FSM plus datapath registers; busy/done are registered alongside the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_op     <= OP_SLA;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_op <= bus.op;
            if (bus.op == OP_MUL) begin
              r_acc    <= '0;
              r_mcand  <= bus.opa;
              r_mplier <= bus.opb;
              r_cnt    <= 6'd32;
              r_busy   <= 1'b1;
              r_state  <= S_MUL_ADD;
            end else if (bus.opb[4:0] == 5'd0) begin
              // Zero shift amount finishes at once with the operand unchanged
              r_result <= bus.opa;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_acc   <= bus.opa;
              r_cnt   <= {1'b0, bus.opb[4:0]};
              r_busy  <= 1'b1;
              r_state <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          r_acc <= bus.alu_out;
          r_cnt <= r_cnt - 6'd1;
          if (r_cnt == 6'd1) begin
            r_result <= bus.alu_out;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        S_MUL_ADD: begin
          if (r_mplier[0]) begin
            r_acc <= bus.alu_out;
          end
          r_state <= S_MUL_SHIFT;
        end
        S_MUL_SHIFT: begin
          r_mcand  <= bus.alu_out;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt - 6'd1;
          if (r_cnt == 6'd1) begin
            r_result <= r_acc;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_state <= S_MUL_ADD;
          end
        end
        S_DONE: begin
          // start is ignored here; always return to idle
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // ALU operand drive decoded from the registered state; idle and done drive zeros
  always_comb begin
    w_alu_a   = '0;
    w_alu_b   = '0;
    w_alu_sel = SEL_ADD;
    case (r_state)
      S_SHIFT: begin
        w_alu_a = r_acc;
        w_alu_b = 32'd1;
        case (r_op)
          OP_SRA:  w_alu_sel = SEL_SRA;
          OP_SRL:  w_alu_sel = SEL_SRL;
          default: w_alu_sel = SEL_SLA;
        endcase
      end
      S_MUL_ADD: begin
        w_alu_a   = r_acc;
        w_alu_b   = r_mcand;
        w_alu_sel = SEL_ADD;
      end
      S_MUL_SHIFT: begin
        w_alu_a   = r_mcand;
        w_alu_b   = 32'd1;
        w_alu_sel = SEL_SLA;
      end
      default: begin
        w_alu_a   = '0;
        w_alu_b   = '0;
        w_alu_sel = SEL_ADD;
      end
    endcase
  end

  assign bus.alu_a   = w_alu_a;
  assign bus.alu_b   = w_alu_b;
  assign bus.alu_sel = w_alu_sel;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.result  = r_result;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: behavioural shared ALU, a reference model working
// from whole-operation arithmetic, directed corner cases, and random operations.
module tb_alu_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] dbg_state;

  alu_seq_ctrl_if bus ();

  alu_seq_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // Clock and reset
  always #5 clk = ~clk;

  // Shared ALU behaviour as seen by the controller
  always_comb begin
    logic signed [31:0] sa;
    sa = bus.alu_a;
    bus.alu_out = '0;
    case (bus.alu_sel)
      4'd0: bus.alu_out = bus.alu_a + bus.alu_b;
      4'd6: bus.alu_out = bus.alu_a << bus.alu_b[0];
      4'd7: bus.alu_out = sa >>> bus.alu_b[0];
      4'd8: bus.alu_out = bus.alu_a >> bus.alu_b[0];
      default: bus.alu_out = '0;
    endcase
  end

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model: whole operation from the operands
  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic signed [31:0] sa;
    int amt;
    sa  = a;
    amt = int'(b[4:0]);
    case (op)
      2'b00:   return a << amt;
      2'b01:   return sa >>> amt;
      2'b10:   return a >> amt;
      default: return a * b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [1:0] op, input logic [31:0] b);
    if (op == 2'b11) return 64;
    return int'(b[4:0]);
  endfunction

  // Driver: issue one operation, optionally spray ignored starts, then check
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit stray_on);
    int exp_lat;
    int lat;
    logic [31:0] exp_res;
    exp_q.push_back(ref_result(op, a, b));
    exp_lat = ref_latency(op, b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.opa   = a;
    bus.opb   = b;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 0;
    while (bus.done !== 1'b1 && lat < 200) begin
      check("busy", {31'b0, bus.busy}, 32'd1);
      lat++;
      bus.op    = 2'($urandom);
      bus.opa   = $urandom;
      bus.opb   = $urandom;
      bus.start = stray_on && (($urandom_range(0, 2) == 0) || lat == 9);
      @(negedge clk);
    end
    check("latency", lat, exp_lat);
    check("done", {31'b0, bus.done}, 32'd1);
    exp_res = exp_q.pop_front();
    check("result", bus.result, exp_res);
    check("busy_in_done", {31'b0, bus.busy}, 32'd0);
    check("alu_sel_done", {28'b0, bus.alu_sel}, 32'd0);
    check("alu_a_done", bus.alu_a, 32'd0);
    check("alu_b_done", bus.alu_b, 32'd0);
    // A start during the done cycle must be ignored
    bus.start = 1'b1;
    bus.op    = 2'($urandom);
    bus.opa   = $urandom;
    bus.opb   = $urandom | 32'h1;
    @(negedge clk);
    bus.start = 1'b0;
    check("done_width", {31'b0, bus.done}, 32'd0);
    check("start_in_done", {31'b0, bus.busy}, 32'd0);
    check("result_held", bus.result, exp_res);
  endtask

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.opa   = '0;
    bus.opb   = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    check("rst_done", {31'b0, bus.done}, 32'd0);
    check("rst_result", bus.result, 32'd0);
    check("rst_alu_sel", {28'b0, bus.alu_sel}, 32'd0);
    check("rst_alu_a", bus.alu_a, 32'd0);
    rst = 1'b0;

    // Directed corner cases
    run_op(2'b00, 32'h0000_0001, 32'd4, 1'b1);
    run_op(2'b01, 32'h8000_0000, 32'd31, 1'b1);
    run_op(2'b10, 32'h8000_0000, 32'd31, 1'b1);
    run_op(2'b10, 32'h8000_0000, 32'h0000_0020, 1'b1);
    run_op(2'b11, 32'h0001_0003, 32'h0001_0005, 1'b1);
    run_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);

    // Reset in the middle of a multiply, with start asserted alongside it
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'b11;
    bus.opa   = 32'h1234_5678;
    bus.opb   = 32'h0000_00FF;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (19) @(negedge clk);
    rst       = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    check("midrst_busy", {31'b0, bus.busy}, 32'd0);
    check("midrst_done", {31'b0, bus.done}, 32'd0);
    check("midrst_result", bus.result, 32'd0);
    check("midrst_alu_sel", {28'b0, bus.alu_sel}, 32'd0);
    rst       = 1'b0;
    bus.start = 1'b0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      check("no_done_after_rst", {31'b0, bus.done | bus.busy}, 32'd0);
    end
    run_op(2'b00, 32'h0000_0001, 32'd4, 1'b0);

    // Random operations
    for (int i = 0; i < 30; i++) begin
      logic [1:0]  rop;
      logic [31:0] ra;
      logic [31:0] rb;
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      if ($urandom_range(0, 5) == 0) rb[4:0] = 5'd0;
      run_op(rop, ra, rb, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have: rst  in  1  reset, synchronous and active-high, one clock domain (clk).
REQ-003 SHALL have: start  in  1  request pulse, sampled only in IDLE.
REQ-004 SHALL have: op  in  2  00=SLA, 01=SRA, 10=SRL, 11=MUL (low 32 bits of product).
REQ-005 SHALL have: opa  in  32  shift source / multiplicand, captured on accepted start.
REQ-006 SHALL have: opb  in  32  shift amount (bits [4:0] only) / multiplier, captured on accepted start.
REQ-007 SHALL have: busy  out  1  high in SHIFT, MUL_ADD, MUL_SHIFT.
REQ-008 SHALL have: done  out  1  one-cycle pulse, high only in DONE.
REQ-009 SHALL have: result  out  32  registered result, held from DONE until next accepted start.
REQ-010 SHALL have: alu_a, alu_b  out  32 each  ALU operand drive.
REQ-011 SHALL have: alu_sel  out  4  ALU select: 0=add, 6=SLA-by-b[0], 7=SRA-by-b[0], 8=SRL-by-b[0].
REQ-012 SHALL have: alu_out  in  32  combinational result of the shared 32-bit ALU.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT, MUL_ADD, MUL_SHIFT, DONE; all arithmetic via the external ALU, none local except counter and multiplier right-shift.
REQ-014 IDLE: alu_a=0, alu_b=0, alu_sel=0; start=1 at edge k latches opa/opb/op, starts cycle k+1.
REQ-015 Shift op, cnt=opb[4:0]: cnt=0 -> DONE at k+1 with result=opa; else -> SHIFT with acc=opa.
REQ-016 SHIFT cycle: alu_a=acc, alu_b=1, alu_sel=6/7/8 per op; acc<=alu_out; cnt<=cnt-1; cnt reaching 0 -> DONE.
REQ-017 Shift by n (1..31): SHIFT cycles k+1..k+n, DONE at k+n+1; opb[31:5] ignored.
REQ-018 MUL: prod=0, mcand=opa, mplier=opb, iter=32; enter MUL_ADD.
REQ-019 MUL_ADD: alu_a=prod, alu_b=mcand, alu_sel=0; prod<=alu_out only if mplier[0]=1; -> MUL_SHIFT.
REQ-020 MUL_SHIFT: alu_a=mcand, alu_b=1, alu_sel=6; mcand<=alu_out; mplier<=mplier>>1; iter<=iter-1; iter reaching 0 -> DONE else MUL_ADD.
REQ-021 MUL latency fixed: 64 busy cycles, DONE at k+65; no early exit on zero multiplier; carries past bit 31 discarded.
REQ-022 DONE: result<=final acc/prod, done=1, busy=0, ALU outputs as IDLE; next cycle -> IDLE unconditionally.
REQ-023 start while busy or in DONE SHALL be ignored, no effect on state, operands or result.
REQ-024 Captured operands SHALL be unaffected by opa/opb/op changes after acceptance.

Reset
REQ-025 rst=1 at any edge, any state (incl. mid-operation) -> next cycle IDLE, busy=0, done=0, result=0, alu_a=alu_b=0, alu_sel=0, internal counters/regs cleared.
REQ-026 rst SHALL dominate start in the same cycle; operation in progress is abandoned, no done pulse.

Verification
REQ-027 SLA opa=0x00000001 opb=4 start at k -> busy k+1..k+4, done=1 at k+5, result=0x00000010.
REQ-028 SRA opa=0x80000000 opb=31 -> done at k+32, result=0xFFFFFFFF; same with SRL -> 0x00000001.
REQ-029 SRL opa=0x80000000 opb=0x00000020 (amount 0) -> no busy cycle, done at k+1, result=0x80000000.
REQ-030 MUL 0x00010003 x 0x00010005 -> done at k+65, result=0x0008000F; MUL 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000001.
REQ-031 MUL accepted, second start at k+10 with different operands -> ignored, first result delivered at k+65; start during DONE cycle ignored.
REQ-032 rst=1 at k+20 of MUL -> from k+21 busy=0, done=0, result=0, alu_sel=0; no done pulse follows; new start then behaves as REQ-027.
